// File: rtl/serialize_pkg.sv
// serialize_pkg: shared index-width helper and FSM state encoding for serialize_multi.
package serialize_pkg;
  typedef enum logic {ST_IDLE = 1'b0, ST_SHIFT = 1'b1} state_t;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/serialize_next_chan.sv
// serialize_next_chan: lowest set bit of i_mask at or above i_from.
module serialize_next_chan #(
  parameter int nch = 8,
  parameter int cw  = 3,
  parameter int fw  = 4
) (
  input  logic [nch-1:0] i_mask,
  input  logic [fw-1:0]  i_from,
  output logic           o_found,
  output logic [cw-1:0]  o_idx
);
  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    for (int k = nch - 1; k >= 0; k--) begin
      if (i_mask[k] && k >= int'(i_from)) begin
        o_found = 1'b1;
        o_idx   = cw'(k);
      end
    end
  end
endmodule

// File: rtl/serialize_multi.sv
// serialize_multi: snap nch samples, emit them one per clk onto a daisy-chained stream; forwards upstream when idle.
// Optional channel mask enabled by SERIALIZE_MULTI_MASK_EN.
module serialize_multi
  import serialize_pkg::*;
#(
  parameter int dwi = 28,
  parameter int nch = 8,
  parameter int cw  = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               samp,
  input  logic [nch*dwi-1:0] data_in,
  input  logic [dwi-1:0]     stream_in,
  input  logic               gate_in,
`ifdef SERIALIZE_MULTI_MASK_EN
  input  logic [nch-1:0]     chan_mask,
`endif
  output logic [dwi-1:0]     stream_out,
  output logic               gate_out,
  output logic [cw-1:0]      chan_out,
  output logic               strobe_out,
  output logic               busy,
  output logic               overrun,
  input  logic               clr_err
);
  localparam int FW = clog2(nch + 1);
  state_t             r_state, w_state_n;
  logic [cw-1:0]      r_idx, w_idx_n, w_first, w_nxt;
  logic [nch*dwi-1:0] r_shadow;
  logic [FW-1:0]      w_from;
  logic               w_first_ok, w_nxt_ok, w_snap, w_shift, w_emit, w_err;
  logic [dwi-1:0]     w_word;
  assign w_shift = r_state == ST_SHIFT;
  assign w_snap  = samp & w_first_ok;
  assign w_emit  = w_snap | w_shift;
  assign w_from  = (w_snap ? FW'(w_first) : FW'(r_idx)) + FW'(1);
`ifdef SERIALIZE_MULTI_MASK_EN
  logic [nch-1:0] r_mask;
  serialize_next_chan #(.nch(nch), .cw(cw), .fw(FW)) u_first (
    .i_mask(chan_mask), .i_from('0), .o_found(w_first_ok), .o_idx(w_first)
  );
  serialize_next_chan #(.nch(nch), .cw(cw), .fw(FW)) u_next (
    .i_mask(w_snap ? chan_mask : r_mask), .i_from(w_from), .o_found(w_nxt_ok), .o_idx(w_nxt)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_mask <= '0;
    else if (w_snap) r_mask <= chan_mask;
  end
`else
  assign w_first_ok = 1'b1;
  assign w_first    = '0;
  assign w_nxt      = cw'(w_from);
  assign w_nxt_ok   = w_from < FW'(nch);
`endif
  // A fresh snap is read straight from data_in since the shadow loads on this same edge.
  assign w_word = w_snap ? data_in[w_first*dwi +: dwi] : r_shadow[r_idx*dwi +: dwi];
  assign w_err  = (gate_in & w_emit) | (w_snap & w_shift);
  always_comb begin
    w_state_n = w_emit ? (w_nxt_ok ? ST_SHIFT : ST_IDLE) : r_state;
    w_idx_n   = w_emit ? w_nxt : r_idx;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_idx      <= '0;
      r_shadow   <= '0;
      stream_out <= '0;
      gate_out   <= 1'b0;
      chan_out   <= '0;
      overrun    <= 1'b0;
    end else begin
      r_state    <= w_state_n;
      r_idx      <= w_idx_n;
      r_shadow   <= w_snap ? data_in : r_shadow;
      stream_out <= w_emit ? w_word : stream_in;
      gate_out   <= w_emit | gate_in;
      chan_out   <= w_emit ? (w_snap ? w_first : r_idx) : '0;
      overrun    <= w_err | (overrun & ~clr_err);
    end
  end
  assign strobe_out = samp;
  assign busy       = w_shift;
endmodule
